// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the execute stage. It produces the HI/LO pair
// for mult, multu, div and divu. Multiply has a fixed latency; divide is radix-2 restoring.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             divzero_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, divz_q, divz_d;

    // Extending both operands to 2*WIDTH makes a modular multiply correct for signed and unsigned
    function automatic logic [2*WIDTH-1:0] mul_full(input logic sgn,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ae, be;
        ae = {{WIDTH{sgn & a[WIDTH-1]}}, a};
        be = {{WIDTH{sgn & b[WIDTH-1]}}, b};
        return ae * be;
    endfunction

    logic [WIDTH-1:0] bmag, rem_nx, quo_nx;
    logic [WIDTH:0]   rem_sh, diff;
    logic             step_ok, q_neg, r_neg;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        bmag    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, bmag};
        step_ok = ~diff[WIDTH];
        rem_nx  = step_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx  = {quo_q[WIDTH-2:0], step_ok};
        q_neg   = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        r_neg   = sgn_q & a_q[WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        dz_d    = dz_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        divz_d  = 1'b0;
        case (state_q)
            IDLE: if (start_i && !cancel_i) begin
                sgn_d = ~op_i[0];
                a_d   = a_i;
                b_d   = b_i;
                if (op_i[1]) begin
                    state_d = DIV;
                    cnt_d   = CW'(WIDTH - 1);
                    rem_d   = '0;
                    quo_d   = (~op_i[0] && a_i[WIDTH-1]) ? -a_i : a_i;
                    dz_d    = (b_i == '0);
                end else if (MUL_STAGES == 1) begin
                    {hi_d, lo_d} = mul_full(~op_i[0], a_i, b_i);
                    done_d       = 1'b1;
                end else begin
                    state_d = MUL;
                    cnt_d   = CW'(MUL_STAGES - 2);
                end
            end
            MUL: if (cancel_i) begin
                state_d = IDLE;
            end else if (cnt_q == '0) begin
                {hi_d, lo_d} = mul_full(sgn_q, a_q, b_q);
                done_d       = 1'b1;
                state_d      = IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            DIV: if (cancel_i) begin
                state_d = IDLE;
            end else begin
                if (!dz_q) begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            // FIX performs the last iteration together with the sign correction
            FIX: if (cancel_i) begin
                state_d = IDLE;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (dz_q) begin
                    lo_d   = '1;
                    hi_d   = a_q;
                    divz_d = 1'b1;
                end else begin
                    lo_d = q_neg ? -quo_nx : quo_nx;
                    hi_d = r_neg ? -rem_nx : rem_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign divzero_o = divz_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Directed cases are followed by random operations,
// and the random results are compared against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W  = 32;
    localparam int MS = 2;
    localparam int DIV_LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst, start_i, cancel_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i, b_i;
    logic         busy_o, done_o, divzero_o;
    logic [W-1:0] hi_o, lo_o;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .cancel_i(cancel_i), .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
        .divzero_o(divzero_o)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero like the ISA
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint sa, sb, p, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
            default: begin
                if (b == 0) begin
                    dz = 1'b1; lo = 32'hFFFF_FFFF; hi = a;
                end else if (op == 2'd2) begin
                    q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
                end else begin
                    lo = a / b; hi = a % b;
                end
            end
        endcase
    endfunction

    // Called just after a negedge; returns at the negedge of the done cycle (lat=-1 on timeout).
    // seq_ok: busy high and hi/lo/divzero steady on every cycle before done, busy low on done.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output bit seq_ok);
        logic [31:0] h0, l0;
        h0 = hi_o; l0 = lo_o;
        hi = '0; lo = '0; dz = 1'b0; lat = -1; seq_ok = 1'b1;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(negedge clk);
        start_i = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        for (int k = 1; k <= 60; k++) begin
            if (done_o) begin
                lat = k; hi = hi_o; lo = lo_o; dz = divzero_o;
                if (busy_o) seq_ok = 1'b0;
                break;
            end
            if (!busy_o || hi_o !== h0 || lo_o !== l0 || divzero_o) seq_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start_i = 1'b0; cancel_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (divzero_o !== 1'b0) begin errors++; $display("FAIL reset_divzero got=%b exp=0", divzero_o); end
        checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_then_divu;
        int lat; logic [31:0] hi, lo; logic dz; bit ok;
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, lat, hi, lo, dz, ok);
        checks++; if (lat != MS) begin errors++; $display("FAIL multu_latency got=%0d exp=%0d", lat, MS); end
        checks++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_result got=%h/%h exp=00000001/fffffffe", hi, lo); end
        checks++; if (!ok) begin errors++; $display("FAIL multu_busy_seq got=bad exp=busy only cycle 1"); end
        run_op(2'd0, -32'sd3, 32'd5, lat, hi, lo, dz, ok);
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_neg got=%h/%h exp=ffffffff/fffffff1", hi, lo); end
        run_op(2'd3, 32'd100, 32'd7, lat, hi, lo, dz, ok);
        checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL divu_b2b_latency got=%0d exp=%0d", lat, DIV_LAT); end
        checks++; if (hi !== 32'd2 || lo !== 32'd14 || dz !== 1'b0) begin errors++; $display("FAIL divu_result got=%0d/%0d dz=%b exp=2/14 dz=0", hi, lo, dz); end
        checks++; if (!ok) begin errors++; $display("FAIL divu_busy_seq got=bad exp=busy cycles 1..%0d", W); end
    endtask

    task automatic test_div_corners;
        int lat; logic [31:0] hi, lo; logic dz; bit ok;
        run_op(2'd2, -32'sd7, 32'd2, lat, hi, lo, dz, ok);
        checks++; if (lat != DIV_LAT) begin errors++; $display("FAIL div_neg_latency got=%0d exp=%0d", lat, DIV_LAT); end
        checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo, dz, ok);
        checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0 || dz !== 1'b0) begin errors++; $display("FAIL div_overflow got=%h/%h dz=%b exp=00000000/80000000 dz=0", hi, lo, dz); end
        run_op(2'd3, 32'd100, 32'd0, lat, hi, lo, dz, ok);
        checks++; if (lat != DIV_LAT || dz !== 1'b1) begin errors++; $display("FAIL divzero_pulse got=lat%0d dz=%b exp=lat%0d dz=1", lat, dz, DIV_LAT); end
        checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd100) begin errors++; $display("FAIL divzero_result got=%h/%h exp=00000064/ffffffff", hi, lo); end
        @(negedge clk);
        checks++; if (divzero_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL divzero_one_cycle got=dz%b done%b exp=0/0", divzero_o, done_o); end
        run_op(2'd2, 32'd50, -32'sd6, lat, hi, lo, dz, ok);
        checks++; if (dz !== 1'b0 || lo !== -32'sd8 || hi !== 32'd2) begin errors++; $display("FAIL div_after_zero got=%h/%h dz=%b exp=00000002/fffffff8 dz=0", hi, lo, dz); end
    endtask

    task automatic test_random;
        int lat, exp_lat; logic [31:0] hi, lo, ehi, elo, a, b; logic dz, edz; bit ok;
        logic [1:0] op;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            ref_op(op, a, b, ehi, elo, edz);
            exp_lat = op[1] ? DIV_LAT : MS;
            run_op(op, a, b, lat, hi, lo, dz, ok);
            checks++; if (lat != exp_lat || !ok) begin errors++; $display("FAIL rnd%0d_timing op=%0d got=lat%0d seq%0d exp=lat%0d seq1", i, op, lat, ok, exp_lat); end
            checks++; if (hi !== ehi || lo !== elo || dz !== edz) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h/%h dz=%b exp=%h/%h dz=%b", i, op, a, b, hi, lo, dz, ehi, elo, edz); end
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_cancel;
        int lat; logic [31:0] x, y, hi, lo; logic dz; bit ok, seen_done;
        run_op(2'd0, 32'h1234_5678, 32'hFEDC_BA98, lat, x, y, dz, ok);
        start_i = 1'b1; op_i = 2'd2; a_i = 32'd999; b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        seen_done = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (done_o) seen_done = 1'b1;
            @(negedge clk);
        end
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b exp=0", busy_o); end
        for (int k = 0; k < 40; k++) begin
            if (done_o) seen_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_done) begin errors++; $display("FAIL cancel_no_done got=done exp=none"); end
        checks++; if (hi_o !== x || lo_o !== y) begin errors++; $display("FAIL cancel_hilo_hold got=%h/%h exp=%h/%h", hi_o, lo_o, x, y); end
        start_i = 1'b1; cancel_i = 1'b1; op_i = 2'd1; a_i = 32'd3; b_i = 32'd4;
        @(negedge clk);
        start_i = 1'b0; cancel_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL start_cancel_busy got=%b exp=0", busy_o); end
        seen_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done_o || busy_o) seen_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_done || lo_o !== y) begin errors++; $display("FAIL start_cancel_idle got=activity lo=%h exp=idle lo=%h", lo_o, y); end
        run_op(2'd1, 32'd6, 32'd7, lat, hi, lo, dz, ok);
        checks++; if (lat != MS || lo !== 32'd42) begin errors++; $display("FAIL after_cancel got=lat%0d lo=%0d exp=lat%0d lo=42", lat, lo, MS); end
    endtask

    task automatic test_reset_mid;
        bit seen_done;
        start_i = 1'b1; op_i = 2'd3; a_i = 32'd500; b_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++; if (busy_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL reset_mid got=busy%b %h/%h exp=busy0 0/0", busy_o, hi_o, lo_o); end
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_o) seen_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_done) begin errors++; $display("FAIL reset_mid_no_done got=done exp=none"); end
    endtask

    task automatic test_start_while_busy;
        int lat; bit seen_done;
        lat = -1;
        start_i = 1'b1; op_i = 2'd3; a_i = 32'd100; b_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0; a_i = '0; b_i = '0;
        for (int k = 1; k <= 60; k++) begin
            if (done_o) begin lat = k; break; end
            if (k == 3) begin start_i = 1'b1; op_i = 2'd1; a_i = 32'd11; b_i = 32'd13; end
            else start_i = 1'b0;
            @(negedge clk);
        end
        start_i = 1'b0;
        checks++; if (lat != DIV_LAT || lo_o !== 32'd14 || hi_o !== 32'd2) begin errors++; $display("FAIL start_busy_ignored got=lat%0d %0d/%0d exp=lat%0d 2/14", lat, hi_o, lo_o, DIV_LAT); end
        @(negedge clk);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_o || busy_o) seen_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen_done) begin errors++; $display("FAIL start_busy_no_extra got=activity exp=idle"); end
    endtask

    initial begin
        test_reset();
        test_mul_then_divu();
        test_div_corners();
        test_random();
        test_cancel();
        test_reset_mid();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
